// File: rtl/id_exe_pkg.sv
`default_nettype none
// ============================================================================
// Module   : id_exe_pkg
// Purpose  : Shared widths, control-field layout and bubble-gating mask for
//            the ID/EXE pipeline register.
// Revision : 1.0  initial release
// ============================================================================
package id_exe_pkg;

    localparam int DEFAULT_DATA_W     = 16;
    localparam int DEFAULT_REG_ADDR_W = 3;
    localparam int DEFAULT_ALUOP_W    = 3;
    localparam int DEFAULT_CNT_W      = 16;

    // Fixed low-order control fields, LSB first.
    localparam int ALUSRC1_BIT = 0;
    localparam int ALUSRC2_BIT = 1;
    localparam int WB_BIT      = 2;
    localparam int MEMW_BIT    = 3;
    localparam int MEMR_BIT    = 4;
    localparam int ALUOP_LSB   = 5;

    localparam int MASK_MAX_W  = 64;

    function automatic int ctrl_w(input int reg_addr_w, input int aluop_w);
        return reg_addr_w + aluop_w + 6;
    endfunction

    function automatic int regwr_bit(input int aluop_w);
        return ALUOP_LSB + aluop_w;
    endfunction

    function automatic int rd2_lsb(input int aluop_w);
        return ALUOP_LSB + aluop_w + 1;
    endfunction

    localparam int REGWR_BIT = regwr_bit(DEFAULT_ALUOP_W);
    localparam int RD2_LSB   = rd2_lsb(DEFAULT_ALUOP_W);

    // Bits that cause architectural side effects; cleared on bubbles.
    function automatic logic [MASK_MAX_W-1:0] side_effect_mask(input int aluop_w);
        logic [MASK_MAX_W-1:0] m;
        m = '0;
        m[regwr_bit(aluop_w)] = 1'b1;
        m[MEMR_BIT]           = 1'b1;
        m[MEMW_BIT]           = 1'b1;
        m[WB_BIT]             = 1'b1;
        return m;
    endfunction

    localparam logic [MASK_MAX_W-1:0] SIDE_EFFECT_MASK = side_effect_mask(DEFAULT_ALUOP_W);

endpackage
`default_nettype wire

// File: rtl/id_exe_stage_reg_sat_counter.sv
`default_nettype none
// ============================================================================
// Module   : sat_counter
// Purpose  : Saturating up-counter with synchronous active-high reset.
// Revision : 1.0  initial release
// ============================================================================
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (inc && (r_count != {W{1'b1}})) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/id_exe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module   : id_exe_stage_reg
// Purpose  : ID/EXE pipeline register with valid/ready handshake, one-entry
//            skid buffer, synchronous flush and saturating statistics.
// Revision : 1.0  initial release
// ============================================================================
module id_exe_stage_reg
    import id_exe_pkg::*;
#(
    parameter int DATA_W     = DEFAULT_DATA_W,
    parameter int REG_ADDR_W = DEFAULT_REG_ADDR_W,
    parameter int ALUOP_W    = DEFAULT_ALUOP_W,
    parameter int CNT_W      = DEFAULT_CNT_W,
    localparam int CTRL_W    = ctrl_w(REG_ADDR_W, ALUOP_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] ctrl_in,
    input  logic [DATA_W-1:0] imm_in,
    input  logic [DATA_W-1:0] bus1_in,
    input  logic [DATA_W-1:0] bus2_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] ctrl_out,
    output logic [DATA_W-1:0] imm_out,
    output logic [DATA_W-1:0] bus1_out,
    output logic [DATA_W-1:0] bus2_out,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    localparam int                c_PAY_W   = CTRL_W + 3 * DATA_W;
    localparam logic [CTRL_W-1:0] c_SE_MASK = CTRL_W'(side_effect_mask(ALUOP_W));

    logic               r_m_valid;
    logic               r_s_valid;
    logic [c_PAY_W-1:0] r_m_pay;
    logic [c_PAY_W-1:0] r_s_pay;

    logic               w_accept;
    logic               w_drain;
    logic [c_PAY_W-1:0] w_in_pay;
    logic [CTRL_W-1:0]  w_m_ctrl;

    assign w_in_pay = {ctrl_in, imm_in, bus1_in, bus2_in};
    assign w_accept = in_valid && !r_s_valid;
    assign w_drain  = r_m_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_m_valid <= 1'b0;
            r_s_valid <= 1'b0;
            r_m_pay   <= '0;
            r_s_pay   <= '0;
        end else if (flush) begin
            // Payload is kept; only the valid bits are squashed.
            r_m_valid <= 1'b0;
            r_s_valid <= 1'b0;
        end else if (!r_m_valid || w_drain) begin
            if (r_s_valid) begin
                r_m_pay   <= r_s_pay;
                r_m_valid <= 1'b1;
                r_s_valid <= 1'b0;
            end else if (w_accept) begin
                r_m_pay   <= w_in_pay;
                r_m_valid <= 1'b1;
            end else begin
                r_m_valid <= 1'b0;
            end
        end else if (w_accept) begin
            r_s_pay   <= w_in_pay;
            r_s_valid <= 1'b1;
        end
    end

    assign in_ready  = !r_s_valid;
    assign out_valid = r_m_valid;

    assign w_m_ctrl  = r_m_pay[c_PAY_W-1 -: CTRL_W];
    assign ctrl_out  = r_m_valid ? w_m_ctrl : (w_m_ctrl & ~c_SE_MASK);
    assign imm_out   = r_m_pay[3*DATA_W-1 -: DATA_W];
    assign bus1_out  = r_m_pay[2*DATA_W-1 -: DATA_W];
    assign bus2_out  = r_m_pay[DATA_W-1:0];

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (r_m_valid && !out_ready),
        .count (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (flush),
        .count (flush_cnt)
    );

endmodule
`default_nettype wire
